// File: rtl/decoder_scan_ctrl.sv
// Channel-scan controller for a 3x8 decoder: walks sel={c,b,a} with a dwell per channel.
// Optional skip mask is compiled in with `define DECODER_SCAN_SKIP_EN.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_SKIP_EN
  input  logic [7:0]         skip_mask,
`endif
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               active,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_nx;
  logic [2:0]         sel;
  logic [2:0]         sel_nx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nx;
  logic [DWELL_W-1:0] hold;
  logic               wrap_nx;
  logic               done_nx;
  logic [7:0]         en_new;
  logic [7:0]         en_cur;
  logic [2:0]         first_new;
  logic [2:0]         last_cur;
  logic [2:0]         next_cur;
  logic               any_new;
  logic               accept;

`ifdef DECODER_SCAN_SKIP_EN
  logic [7:0] mask;

  assign en_new = ~skip_mask;
  assign en_cur = ~mask;

  // Mask is frozen for the whole scan once start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= 8'h00;
    end else if (accept) begin
      mask <= skip_mask;
    end
  end
`else
  assign en_new = 8'hFF;
  assign en_cur = 8'hFF;
`endif

  assign hold    = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign any_new = |en_new;
  assign accept  = (state == IDLE) && start && !stop && any_new;

  always_comb begin
    first_new = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (en_new[i]) first_new = 3'(i);
    end
  end

  always_comb begin
    last_cur = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (en_cur[i]) last_cur = 3'(i);
    end
  end

  // Nearest enabled channel above sel, modulo 8; stays put if alone
  always_comb begin
    next_cur = sel;
    for (int k = 7; k >= 1; k--) begin
      if (en_cur[3'(sel + 3'(k))]) next_cur = 3'(sel + 3'(k));
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept) begin
          state_nx = SCAN;
          sel_nx   = first_new;
          cnt_nx   = hold;
        end
      end
      (state == SCAN): begin
        if (stop) begin
          state_nx = IDLE;
          sel_nx   = 3'd0;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else if (cnt > DWELL_W'(1)) begin
          cnt_nx = cnt - DWELL_W'(1);
        end else if (!cont && (sel == last_cur)) begin
          state_nx = IDLE;
          sel_nx   = 3'd0;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          sel_nx  = next_cur;
          cnt_nx  = hold;
          wrap_nx = (sel == last_cur);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      cnt   <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
      wrap  <= wrap_nx;
      done  <= done_nx;
    end
  end

  assign a      = sel[0];
  assign b      = sel[1];
  assign c      = sel[2];
  assign active = (state == SCAN);
  assign busy   = active;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomised bench for decoder_scan_ctrl against a channel-list reference model.
// Skip-mask scenarios compile in with `define DECODER_SCAN_SKIP_EN.
module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] dwell;
`ifdef DECODER_SCAN_SKIP_EN
  logic [7:0] skip_mask;
`endif
  logic       a;
  logic       b;
  logic       c;
  logic       active;
  logic       busy;
  logic       wrap;
  logic       done;

  int n_chk;
  int n_pass;

  // reference model: scan walks an ordered list of enabled channels
  int lst[8];
  int n_en;
  bit m_scan;
  int m_pos;
  int m_hold;
  int m_age;
  int e_sel;
  bit e_wrap;
  bit e_done;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .cont(cont),
    .dwell(dwell),
`ifdef DECODER_SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .a(a),
    .b(b),
    .c(c),
    .active(active),
    .busy(busy),
    .wrap(wrap),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic build_list();
    logic [7:0] m;
    m = 8'h00;
`ifdef DECODER_SCAN_SKIP_EN
    m = skip_mask;
`endif
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) begin
        lst[n_en] = i;
        n_en++;
      end
    end
  endtask

  function automatic int hold_of(logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  task automatic model();
    e_wrap = 1'b0;
    e_done = 1'b0;
    if (!rst_n) begin
      m_scan = 1'b0;
    end else if (!m_scan) begin
      if (start && !stop) begin
        build_list();
        if (n_en > 0) begin
          m_scan = 1'b1;
          m_pos  = 0;
          m_hold = hold_of(dwell);
          m_age  = 1;
        end
      end
    end else if (stop) begin
      m_scan = 1'b0;
      e_done = 1'b1;
    end else if (m_age < m_hold) begin
      m_age++;
    end else if (!cont && m_pos == n_en - 1) begin
      m_scan = 1'b0;
      e_done = 1'b1;
    end else begin
      e_wrap = (m_pos == n_en - 1);
      m_pos  = (m_pos + 1) % n_en;
      m_hold = hold_of(dwell);
      m_age  = 1;
    end
    e_sel = m_scan ? lst[m_pos] : 0;
  endtask

  task automatic cmp_all();
    chk("sel", 32'({c, b, a}), 32'(e_sel));
    chk("active", 32'(active), 32'(m_scan));
    chk("busy", 32'(busy), 32'(m_scan));
    chk("wrap", 32'(wrap), 32'(e_wrap));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    cmp_all();
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'({c, b, a}), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    m_scan = 1'b0;
    e_sel  = 0;
    e_wrap = 1'b0;
    e_done = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  int act_cnt;
  int wrap_cnt;
  int done_cnt;
  int ch3_cnt;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_scan = 1'b0;
    m_pos  = 0;
    m_hold = 1;
    m_age  = 0;
    n_en   = 8;
    e_sel  = 0;
    e_wrap = 1'b0;
    e_done = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b1;
    stop   = 1'b0;
    cont   = 1'b0;
    dwell  = 8'd3;
`ifdef DECODER_SCAN_SKIP_EN
    skip_mask = 8'h00;
`endif
    #1;
    cmp_all();
    tick();
    tick();
    #2;
    rst_n = 1'b1;

    // single sweep, dwell 3
    act_cnt  = 0;
    wrap_cnt = 0;
    done_cnt = 0;
    tick();
    start = 1'b0;
    act_cnt += int'(active);
    for (int i = 0; i < 30; i++) begin
      tick();
      act_cnt  += int'(active);
      wrap_cnt += int'(wrap);
      done_cnt += int'(done);
    end
    chk("sweep_active_cycles", 32'(act_cnt), 32'd24);
    chk("sweep_wraps", 32'(wrap_cnt), 32'd0);
    chk("sweep_dones", 32'(done_cnt), 32'd1);

    // continuous, dwell 0
    cont  = 1'b1;
    dwell = 8'd0;
    start = 1'b1;
    tick();
    start    = 1'b0;
    wrap_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      wrap_cnt += int'(wrap);
    end
    chk("cont_wraps", 32'(wrap_cnt), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // stop at channel 5 mid-hold with start held
    dwell = 8'd4;
    start = 1'b1;
    for (int i = 0; i < 100 && !(m_scan && e_sel == 5 && m_age == 2); i++) tick();
    chk("reach_sel5", 32'(m_scan && e_sel == 5), 32'd1);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stop  = 1'b0;
    start = 1'b0;
    tick();

    // async reset during channel 3
    start = 1'b1;
    dwell = 8'd2;
    for (int i = 0; i < 100 && !(m_scan && e_sel == 3); i++) tick();
    chk("reach_sel3", 32'(m_scan && e_sel == 3), 32'd1);
    mid_reset();
    tick();
    chk("restart_sel0", 32'({c, b, a}), 32'd0);
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;

    // dwell re-sample during channel 2
    cont  = 1'b0;
    dwell = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !(m_scan && e_sel == 2); i++) tick();
    dwell   = 8'd5;
    ch3_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ch3_cnt += int'(active && {c, b, a} == 3'd3);
    end
    chk("ch3_hold", 32'(ch3_cnt), 32'd5);
    for (int i = 0; i < 30; i++) tick();

`ifdef DECODER_SCAN_SKIP_EN
    skip_mask = 8'b1010_0101;
    dwell     = 8'd1;
    cont      = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    stop = 1'b1;
    tick();
    stop      = 1'b0;
    skip_mask = 8'hFF;
    start     = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start     = 1'b0;
    skip_mask = 8'b1111_0111;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif

    // randomised traffic
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 40) == 0;
      if (($urandom % 8) == 0) cont = 1'($urandom % 2);
      if (($urandom % 6) == 0) dwell = 8'($urandom % 5);
`ifdef DECODER_SCAN_SKIP_EN
      if (($urandom % 10) == 0)
        skip_mask = (($urandom % 6) == 0) ? 8'hFF : 8'($urandom);
`endif
      if (($urandom % 400) == 0) mid_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, which sets the width of the dwell input and of the dwell counter.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a level-sampled request to begin a scan.
REQ-005 SHALL have port stop, input, 1 bit, a synchronous abort.
REQ-006 SHALL have port cont, input, 1 bit: 1 = continuous scanning, 0 = single sweep.
REQ-007 SHALL have port dwell, input, DWELL_W bits, the hold cycles per channel.
REQ-008 SHALL have port a, b, c, outputs, 1 bit each, the registered channel select with c = MSB and a = LSB, driving the 3x8 decoder select inputs directly.
REQ-009 SHALL have port active, output, 1 bit, the decoder enable, high only while scanning.
REQ-010 SHALL have port busy, output, 1 bit, equal to active.
REQ-011 SHALL have port wrap, output, 1 bit, a one-cycle pulse when the channel wraps to the first channel.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a sweep or on abort.

Function
REQ-013 SHALL implement the two-state FSM IDLE/SCAN; sel denotes {c,b,a}.
REQ-014 In IDLE, SHALL hold sel=0 and active=0.
REQ-015 On a clock edge with start=1 and stop=0 in IDLE, SHALL move to SCAN with sel=first enabled channel, active=1, and load the hold count max(dwell,1); the response is visible the cycle after start is sampled.
REQ-016 In SCAN, SHALL hold each channel for exactly max(dwell,1) cycles; dwell SHALL be re-sampled at each channel advance.
REQ-017 At the end of a hold, SHALL advance to the next enabled channel in ascending order, wrapping 7->0.
REQ-018 When a continuous scan (cont=1) wraps, SHALL assert wrap for the first cycle of the wrapped-to channel.
REQ-019 If cont=0, at the end of the hold of the last enabled channel SHALL return to IDLE (sel=0, active=0) and pulse done in that same cycle; wrap SHALL stay 0.
REQ-020 cont SHALL be sampled at each end of hold.
REQ-021 stop=1 in SCAN SHALL have priority over advance: next cycle IDLE, sel=0, active=0, done=1.
REQ-022 stop=1 in IDLE SHALL have no effect, and SHALL win over start when both are asserted.
REQ-023 start in SCAN SHALL be ignored.
REQ-024 SHALL guarantee that sel never changes while active=0, and that a, b, c are glitch-free register outputs.

Reset
REQ-025 On rst_n=0, SHALL immediately force IDLE, sel=0, active=0, busy=0, wrap=0, done=0, and clear the dwell counter, regardless of clk.
REQ-026 Reset asserted mid-scan SHALL abort without a done pulse.
REQ-027 The first possible start SHALL be sampled on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL provide the macro DECODER_SCAN_SKIP_EN.
REQ-029 With DECODER_SCAN_SKIP_EN defined, SHALL add input skip_mask[7:0]: bit i=1 excludes channel i.
REQ-030 With DECODER_SCAN_SKIP_EN defined, skip_mask SHALL be registered on the accepted start and held for the whole scan.
REQ-031 With DECODER_SCAN_SKIP_EN defined, "first" and "last" enabled channel SHALL mean the lowest and highest unmasked index.
REQ-032 With DECODER_SCAN_SKIP_EN defined, if skip_mask = 8'hFF then start SHALL be ignored and the block SHALL remain in IDLE with no done.
REQ-033 With DECODER_SCAN_SKIP_EN defined and a single enabled channel in continuous mode, SHALL pulse wrap at each hold end while sel is unchanged.
REQ-034 Without DECODER_SCAN_SKIP_EN, the skip_mask port SHALL be absent and all 8 channels SHALL be visited in order 0..7.

Verification
REQ-035 Single sweep: dwell=3, cont=0, one-cycle start -> sel steps 0..7, 3 cycles each, active high 24 cycles, done pulses as active falls, wrap never asserts.
REQ-036 Continuous with dwell=0: dwell=0, cont=1 -> channels change every cycle, wrap=1 in each cycle where sel=0 after 7, done stays 0.
REQ-037 Stop priority: stop asserted at sel=5 mid-hold, start held high -> next cycle sel=0, active=0, done=1, and the block stays IDLE while stop=1.
REQ-038 Async reset: rst_n pulled low between clock edges during SCAN at sel=3 -> outputs clear immediately, no done, and after release a new start begins at sel=0.
REQ-039 Skip mask (DECODER_SCAN_SKIP_EN defined): skip_mask=8'b1010_0101, dwell=1, cont=1 -> sel sequence 1,3,4,6,1,..., wrap on each return to 1; skip_mask=8'hFF -> start ignored.
REQ-040 Dwell re-sampling: dwell changed from 2 to 5 during channel 2 -> channel 2 keeps 2 cycles and channel 3 holds 5 cycles.
